// File: rtl/sync_counter_n_pkg.sv
// Shared constants for the Fujitsu AV unit-cell counter family:
// datasheet propagation delays (ns) and count-direction encodings.
`timescale 1ns/1ps
package fujitsu_av_pkg;

    localparam real T_C43_CK_Q  = 8.37;
    localparam real T_C43_CL_Q  = 5.54;
    localparam real T_C43_CI_CO = 4.07;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/sync_counter_n_if.sv
// Control/data bundle for sync_counter_n. The master drives load, data,
// carry-in, enable and direction; the counter (slave) returns Q, CO and TC.
`timescale 1ns/1ps
interface sync_counter_n_if #(
    parameter int WIDTH = 8
);
    logic             Ln;
    logic [WIDTH-1:0] D;
    logic             CI;
    logic             EN;
    logic             DIR;
    logic [WIDTH-1:0] Q;
    logic             CO;
    logic             TC;

    modport master (output Ln, D, CI, EN, DIR, input Q, CO, TC);
    modport slave  (input Ln, D, CI, EN, DIR, output Q, CO, TC);
endinterface

// File: rtl/sync_counter_n_cnt_slice4.sv
// 4-bit up/down counter slice (C43-style cell): synchronous clear, active-low
// load, count on CI&EN. CO flags the slice terminal value qualified by CI only,
// so slices chain CO->CI into a ripple carry.
`timescale 1ns/1ps
module cnt_slice4
    import fujitsu_av_pkg::*;
(
    input  logic       ck,
    input  logic       cl,
    input  logic       ld_n,
    input  logic [3:0] d,
    input  logic       ci,
    input  logic       en,
    input  logic       dir,
    output logic [3:0] q,
    output logic       co
);

    // Slice state: clear beats load, load beats count.
    always_ff @(posedge ck) begin
        if (cl)
            q <= 4'h0;
        else if (!ld_n)
            q <= d;
        else if (ci && en)
            q <= (dir == DIR_UP) ? q + 4'd1 : q - 4'd1;
    end

    assign co = ci & ((dir == DIR_UP) ? (q == 4'hF) : (q == 4'h0));

endmodule

// File: rtl/sync_counter_n.sv
// N-bit synchronous up/down counter built from cascaded 4-bit slices.
// The top applies the modulus by forcing a load of 0 or MODULUS-1 into the
// slice chain on a wrapping count, and registers the TC wrap pulse.
// Build option: define FUJITSU_DLY_EN to put datasheet propagation delays
// on Q, TC and CO (simulation only); undefined gives zero-delay logic.
`timescale 1ns/1ps
module sync_counter_n
    import fujitsu_av_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH,
    parameter int              UP_DOWN = 1
) (
    input  logic             CK,
    input  logic             CL,
    sync_counter_n_if.slave  bus
);

    localparam int               NS       = WIDTH / 4;
    localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH:0]   MOD_W    = (WIDTH+1)'(MODULUS);
    localparam bit               FULL_MOD = (MODULUS == (64'd1 << WIDTH));

    logic [WIDTH-1:0] q_int;
    logic [WIDTH-1:0] slice_d;
    logic [WIDTH-1:0] force_val;
    logic [NS:0]      carry;
    logic             dir_eff;
    logic             count;
    logic             at_max;
    logic             at_zero;
    logic             over_mod;
    logic             force_ld;
    logic             wrap;
    logic             slice_ld_n;
    logic             tc_int;
    logic             co_int;

    // An up-only build ignores DIR entirely.
    assign dir_eff  = bus.DIR | (UP_DOWN == 0);
    assign count    = bus.CI & bus.EN;
    assign at_max   = (q_int >= MAX_Q);
    assign at_zero  = (q_int == '0);
    assign over_mod = ({1'b0, q_int} >= MOD_W);

    // Decide whether a count must be replaced by a modulus reload.
    always_comb begin
        force_ld  = 1'b0;
        force_val = '0;
        wrap      = 1'b0;
        if (dir_eff == DIR_UP) begin
            if (at_max) begin
                force_ld = 1'b1;
                wrap     = 1'b1;
            end
        end else if (at_zero) begin
            force_ld  = 1'b1;
            force_val = MAX_Q;
            wrap      = 1'b1;
        end else if (over_mod) begin
            force_ld  = 1'b1;
            force_val = MAX_Q;
        end
    end

    // A user load always wins over the modulus reload.
    assign slice_ld_n = bus.Ln & ~(count & force_ld);
    assign slice_d    = bus.Ln ? force_val : bus.D;
    assign carry[0]   = bus.CI;

    for (genvar i = 0; i < NS; i++) begin : g_slice
        cnt_slice4 u_slice (
            .ck   (CK),
            .cl   (CL),
            .ld_n (slice_ld_n),
            .d    (slice_d[4*i +: 4]),
            .ci   (carry[i]),
            .en   (bus.EN),
            .dir  (dir_eff),
            .q    (q_int[4*i +: 4]),
            .co   (carry[i+1])
        );
    end

    // TC marks the cycle that follows a wrapping count edge.
    always_ff @(posedge CK) begin
        if (CL)
            tc_int <= 1'b0;
        else if (!bus.Ln)
            tc_int <= 1'b0;
        else if (count)
            tc_int <= wrap;
        else
            tc_int <= 1'b0;
    end

    // With a full binary modulus the slice ripple carry already is the
    // terminal-count carry; otherwise compare against the modulus bounds.
    assign co_int = FULL_MOD ? carry[NS]
                             : bus.CI & ((dir_eff == DIR_UP) ? at_max : at_zero);

`ifdef FUJITSU_DLY_EN
    logic [WIDTH-1:0] q_dly;
    logic             tc_dly;
    logic             co_dly;

    // Republish the registered state after the clear or clock-to-Q delay.
    always begin
        @(posedge CK);
        if (CL)
            #(T_C43_CL_Q);
        else
            #(T_C43_CK_Q);
        q_dly  = q_int;
        tc_dly = tc_int;
    end

    assign #(T_C43_CI_CO) co_dly = co_int;

    assign bus.Q  = q_dly;
    assign bus.TC = tc_dly;
    assign bus.CO = co_dly;
`else
    assign bus.Q  = q_int;
    assign bus.TC = tc_int;
    assign bus.CO = co_int;
`endif

endmodule
